// File: rtl/axis_collector.sv
`default_nettype none
// ============================================================================
// Module   : axis_collector
// Purpose  : Packet-granular round-robin merge of per-region AXI-Stream outputs,
//            with one selectable interface diverted to a dedicated DPR output.
// Revision : 1.0
// ============================================================================
module axis_collector #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int S_INTF_NUM       = 7
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [S_INTF_NUM-1:0]                    dpr_intf,
  input  logic                                     dpr_intf_valid,
  input  logic [S_INTF_NUM*AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_INTF_NUM*AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_INTF_NUM*AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [S_INTF_NUM-1:0]                    s_axis_tvalid,
  output logic [S_INTF_NUM-1:0]                    s_axis_tready,
  input  logic [S_INTF_NUM-1:0]                    s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     m_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]               m_axis_dpr_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]             m_axis_dpr_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]              m_axis_dpr_tuser,
  output logic                                     m_axis_dpr_tvalid,
  input  logic                                     m_axis_dpr_tready,
  output logic                                     m_axis_dpr_tlast
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(S_INTF_NUM);
  localparam int SEL_W  = S_INTF_NUM;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    pick;
  logic                found;
  logic [IDX_W:0]      scan_sum;
  logic [IDX_W:0]      scan_wrap;
  logic [IDX_W-1:0]    scan_idx;

  logic                dpr_en_q;
  logic [SEL_W-1:0]    dpr_sel_q;
  logic                dpr_busy;
  logic [IDX_W-1:0]    dpr_idx;
  logic [S_INTF_NUM-1:0] diverted;

  logic                main_rdy, main_acc, main_last_in;
  logic                dpr_rdy, dpr_acc, dpr_last_in;
  logic                latch_upd;

  logic [AXIS_DATA_WIDTH-1:0]  main_data_in, dpr_data_in;
  logic [KEEP_W-1:0]           main_keep_in, dpr_keep_in;
  logic [AXIS_TUSER_WIDTH-1:0] main_user_in, dpr_user_in;

  // dpr_en_q guarantees dpr_sel_q < S_INTF_NUM, so the low bits are a valid index
  assign dpr_idx = dpr_sel_q[IDX_W-1:0];

  always_comb begin
    diverted = '0;
    for (int i = 0; i < S_INTF_NUM; i++) begin
      diverted[i] = dpr_en_q && (dpr_sel_q == SEL_W'(i));
    end
  end

  // First valid, non-diverted interface at or after rr_ptr, wrapping at S_INTF_NUM-1
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    scan_sum  = '0;
    scan_wrap = '0;
    scan_idx  = '0;
    for (int k = 0; k < S_INTF_NUM; k++) begin
      scan_sum  = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      scan_wrap = scan_sum - (IDX_W+1)'(S_INTF_NUM);
      scan_idx  = (scan_sum > (IDX_W+1)'(S_INTF_NUM-1)) ? scan_wrap[IDX_W-1:0]
                                                         : scan_sum[IDX_W-1:0];
      if (!found && s_axis_tvalid[scan_idx] && !diverted[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign main_data_in = s_axis_tdata[int'(grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign main_keep_in = s_axis_tkeep[int'(grant)*KEEP_W +: KEEP_W];
  assign main_user_in = s_axis_tuser[int'(grant)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
  assign main_last_in = s_axis_tlast[grant];

  assign dpr_data_in  = s_axis_tdata[int'(dpr_idx)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign dpr_keep_in  = s_axis_tkeep[int'(dpr_idx)*KEEP_W +: KEEP_W];
  assign dpr_user_in  = s_axis_tuser[int'(dpr_idx)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
  assign dpr_last_in  = s_axis_tlast[dpr_idx];

  assign main_rdy = !m_axis_tvalid || m_axis_tready;
  assign dpr_rdy  = !m_axis_dpr_tvalid || m_axis_dpr_tready;
  assign main_acc = (state == BUSY) && s_axis_tvalid[grant] && main_rdy;
  assign dpr_acc  = dpr_en_q && s_axis_tvalid[dpr_idx] && dpr_rdy;

  // Diversion target may only move when neither path is inside a packet,
  // including a DPR packet whose first beat is being accepted right now.
  assign latch_upd = (state == IDLE) && !found && !dpr_busy && !(dpr_acc && !dpr_last_in);

  always_comb begin
    s_axis_tready = '0;
    if (state == BUSY) begin
      s_axis_tready[grant] = main_rdy;
    end
    if (dpr_en_q) begin
      s_axis_tready[dpr_idx] = dpr_rdy;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (main_acc && main_last_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if ((state == IDLE) && found) begin
        grant <= pick;
      end
      if (main_acc && main_last_in) begin
        rr_ptr <= (grant == IDX_W'(S_INTF_NUM-1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      dpr_en_q  <= 1'b0;
      dpr_sel_q <= '0;
      dpr_busy  <= 1'b0;
    end else begin
      if (latch_upd) begin
        dpr_en_q  <= dpr_intf_valid && (dpr_intf < SEL_W'(S_INTF_NUM));
        dpr_sel_q <= dpr_intf;
      end
      if (dpr_acc) begin
        dpr_busy <= !dpr_last_in;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (main_acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= main_last_in;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (main_acc) begin
      m_axis_tdata <= main_data_in;
      m_axis_tkeep <= main_keep_in;
      m_axis_tuser <= main_user_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_dpr_tvalid <= 1'b0;
      m_axis_dpr_tlast  <= 1'b0;
    end else if (dpr_acc) begin
      m_axis_dpr_tvalid <= 1'b1;
      m_axis_dpr_tlast  <= dpr_last_in;
    end else if (m_axis_dpr_tready) begin
      m_axis_dpr_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (dpr_acc) begin
      m_axis_dpr_tdata <= dpr_data_in;
      m_axis_dpr_tkeep <= dpr_keep_in;
      m_axis_dpr_tuser <= dpr_user_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_collector
// Purpose  : Directed and randomized bench for axis_collector with a
//            packet-level round-robin / diversion reference model.
// Revision : 1.0
// ============================================================================
module tb_axis_collector;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int N  = 7;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      dpr_intf;
  logic              dpr_intf_valid;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N*KW-1:0]   s_axis_tkeep;
  logic [N*UW-1:0]   s_axis_tuser;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N-1:0]      s_axis_tlast;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [DW-1:0]     m_axis_dpr_tdata;
  logic [KW-1:0]     m_axis_dpr_tkeep;
  logic [UW-1:0]     m_axis_dpr_tuser;
  logic              m_axis_dpr_tvalid;
  logic              m_axis_dpr_tready;
  logic              m_axis_dpr_tlast;

  always #5 aclk = ~aclk;

  axis_collector #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .S_INTF_NUM      (N)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .dpr_intf         (dpr_intf),
    .dpr_intf_valid   (dpr_intf_valid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_dpr_tdata (m_axis_dpr_tdata),
    .m_axis_dpr_tkeep (m_axis_dpr_tkeep),
    .m_axis_dpr_tuser (m_axis_dpr_tuser),
    .m_axis_dpr_tvalid(m_axis_dpr_tvalid),
    .m_axis_dpr_tready(m_axis_dpr_tready),
    .m_axis_dpr_tlast (m_axis_dpr_tlast)
  );

  // Source queues drive the DUT; mq/plen are the model's copy of the same packets.
  beat_t src_q[N][$];
  beat_t mq[N][$];
  int    plen[N][$];
  int    acc_cyc[N][$];
  beat_t exp_m[$], exp_d[$], obs_m[$], obs_d[$];
  int    obs_m_cyc[$], obs_d_cyc[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mrr      = 0;
  int rdy_mode = 0;
  int pat_idx  = 0;
  bit dpr_rand = 1'b0;
  int pat[6]   = '{1, 0, 0, 1, 0, 1};
  logic [N-1:0] ready_mask = '1;

  logic  prev_mv = 1'b0, prev_mr = 1'b0, prev_dv = 1'b0, prev_dr = 1'b0, prev_rst = 1'b1;
  beat_t prev_mb, prev_db;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mbeat();
    return {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
  endfunction

  function automatic beat_t dbeat();
    return {m_axis_dpr_tdata, m_axis_dpr_tkeep, m_axis_dpr_tuser, m_axis_dpr_tlast};
  endfunction

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_axis_tvalid[i]            = 1'b1;
        s_axis_tdata[i*DW +: DW]    = b.d;
        s_axis_tkeep[i*KW +: KW]    = b.k;
        s_axis_tuser[i*UW +: UW]    = b.u;
        s_axis_tlast[i]             = b.l;
      end else begin
        s_axis_tvalid[i]            = 1'b0;
        s_axis_tlast[i]             = 1'b0;
      end
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = (pat[pat_idx % 6] != 0);
    endcase
    m_axis_dpr_tready = dpr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    beat_t dummy;
    @(negedge aclk);
    if (!prev_rst && prev_mv && !prev_mr)
      check("m_hold", {m_axis_tvalid, mbeat()}, {1'b1, prev_mb});
    if (!prev_rst && prev_dv && !prev_dr)
      check("dpr_hold", {m_axis_dpr_tvalid, dbeat()}, {1'b1, prev_db});
    if (ready_mask != '1)
      check("rdy_mask", s_axis_tready & ~ready_mask, 0);
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      obs_m.push_back(mbeat());
      obs_m_cyc.push_back(cyc);
    end
    if (m_axis_dpr_tvalid && m_axis_dpr_tready) begin
      obs_d.push_back(dbeat());
      obs_d_cyc.push_back(cyc);
    end
    prev_mv = m_axis_tvalid;     prev_mr = m_axis_tready;     prev_mb = mbeat();
    prev_dv = m_axis_dpr_tvalid; prev_dr = m_axis_dpr_tready; prev_db = dbeat();
    prev_rst = areset;
    @(posedge aclk);
    #1;
    cyc++;
    pat_idx++;
    for (int i = 0; i < N; i++) begin
      if (!prev_rst && acc[i]) begin
        dummy = src_q[i].pop_front();
        acc_cyc[i].push_back(cyc - 1);
      end
    end
    drive_inputs();
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = $urandom;
      b.k = KW'($urandom_range(1, 15));
      b.u = UW'($urandom_range(0, 255));
      b.l = (j == len - 1);
      src_q[p].push_back(b);
      mq[p].push_back(b);
    end
    plen[p].push_back(len);
  endtask

  // Model: the diverted port's packets go whole to the DPR stream; all other
  // pending packets leave the main stream in round-robin packet order.
  task automatic build_expected(input int div);
    int p, len;
    bit more;
    if (div >= 0) begin
      while (plen[div].size() > 0) begin
        len = plen[div].pop_front();
        for (int j = 0; j < len; j++) exp_d.push_back(mq[div].pop_front());
      end
    end
    more = 1'b1;
    while (more) begin
      p = -1;
      for (int k = 0; k < N; k++) begin
        if (p < 0 && plen[(mrr + k) % N].size() > 0) p = (mrr + k) % N;
      end
      if (p < 0) begin
        more = 1'b0;
      end else begin
        len = plen[p].pop_front();
        for (int j = 0; j < len; j++) exp_m.push_back(mq[p].pop_front());
        mrr = (p + 1) % N;
      end
    end
  endtask

  task automatic run_check(input string tag, input int budget);
    int t = 0;
    while ((obs_m.size() < exp_m.size() || obs_d.size() < exp_d.size()) && t < budget) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check({tag, "_done"}, t < budget, 1);
    check({tag, "_nm"}, obs_m.size(), exp_m.size());
    check({tag, "_nd"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < exp_m.size(); i++)
      if (i < obs_m.size()) check({tag, "_m"}, obs_m[i], exp_m[i]);
    for (int i = 0; i < exp_d.size(); i++)
      if (i < obs_d.size()) check({tag, "_d"}, obs_d[i], exp_d[i]);
  endtask

  task automatic clear_obs();
    obs_m.delete(); obs_d.delete(); obs_m_cyc.delete(); obs_d_cyc.delete();
    exp_m.delete(); exp_d.delete();
    for (int i = 0; i < N; i++) acc_cyc[i].delete();
  endtask

  task automatic wait_acc(input int p, input int n, input string tag);
    int t = 0;
    while (acc_cyc[p].size() < n && t < 30) begin
      tick();
      t++;
    end
    check(tag, acc_cyc[p].size() >= n, 1);
  endtask

  initial begin
    int s, div, npk;
    areset = 1'b1; dpr_intf = '0; dpr_intf_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0;
    drive_inputs();
    repeat (3) tick();
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_dvalid", m_axis_dpr_tvalid, 0);
    check("rst_sready", s_axis_tready, 0);
    check("rst_mlast", m_axis_tlast, 0);
    check("rst_dlast", m_axis_dpr_tlast, 0);
    areset = 1'b0;
    tick();

    // Single 3-beat packet on port 2: grant cycle, 1-cycle latency, full rate
    ready_mask = 7'b0000100;
    add_pkt(2, 3); build_expected(-1); drive_inputs();
    s = cyc;
    run_check("t1", 30);
    if (obs_m_cyc.size() >= 3 && acc_cyc[2].size() >= 1) begin
      check("t1_grant", acc_cyc[2][0], s + 1);
      check("t1_lat", obs_m_cyc[0], acc_cyc[2][0] + 1);
      check("t1_rate", obs_m_cyc[2], obs_m_cyc[0] + 2);
    end
    ready_mask = '1;
    clear_obs();

    // Round robin from rr_ptr=0 over ports 0,1,3, then port 0 waits behind port 5
    areset = 1'b1; tick(); areset = 1'b0; tick(); mrr = 0;
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2); build_expected(-1); drive_inputs();
    run_check("t2", 60);
    if (obs_m_cyc.size() >= 6) begin
      check("t2_gap1", obs_m_cyc[2], obs_m_cyc[1] + 2);
      check("t2_gap2", obs_m_cyc[4], obs_m_cyc[3] + 2);
    end
    clear_obs();
    add_pkt(0, 2); add_pkt(5, 2); build_expected(-1); drive_inputs();
    run_check("t2b", 40);
    clear_obs();

    // Back-pressure pattern on a 5-beat packet
    rdy_mode = 2; pat_idx = 0; ready_mask = 7'b0010000;
    add_pkt(4, 5); build_expected(-1); drive_inputs();
    run_check("t3", 60);
    rdy_mode = 0; ready_mask = '1;
    clear_obs();

    // Port 1 diverted while port 0 merges, both at full rate
    dpr_intf = 7'd1; dpr_intf_valid = 1'b1; drive_inputs();
    repeat (2) tick();
    ready_mask = 7'b0000011;
    add_pkt(0, 4); add_pkt(1, 4); build_expected(1); drive_inputs();
    run_check("t4", 40);
    if (obs_m_cyc.size() >= 4 && obs_d_cyc.size() >= 4) begin
      check("t4_mrate", obs_m_cyc[3], obs_m_cyc[0] + 3);
      check("t4_drate", obs_d_cyc[3], obs_d_cyc[0] + 3);
    end
    ready_mask = '1;
    clear_obs();

    // Retarget diversion mid-packet: port 1 packet stays whole on the DPR path
    add_pkt(1, 4); build_expected(1); drive_inputs();
    wait_acc(1, 2, "t5_wait");
    dpr_intf = 7'd2; drive_inputs();
    run_check("t5a", 40);
    clear_obs();
    repeat (3) tick();
    add_pkt(1, 2); add_pkt(2, 3); build_expected(2); drive_inputs();
    run_check("t5b", 40);
    clear_obs();
    dpr_intf_valid = 1'b0; drive_inputs();
    repeat (2) tick();

    // Reset in the middle of a packet drops it and restarts arbitration at port 0
    add_pkt(0, 4); drive_inputs();
    wait_acc(0, 2, "t6_wait");
    areset = 1'b1;
    tick();
    check("t6_mvalid", m_axis_tvalid, 0);
    check("t6_dvalid", m_axis_dpr_tvalid, 0);
    check("t6_sready", s_axis_tready, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); mq[i].delete(); plen[i].delete();
    end
    clear_obs();
    areset = 1'b0; drive_inputs();
    tick();
    mrr = 0;
    add_pkt(6, 2); add_pkt(0, 2); build_expected(-1); drive_inputs();
    run_check("t6", 40);
    clear_obs();

    // Randomized traffic; a draw of N selects "no diversion" via an out-of-range index
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(0, N);
      rdy_mode = 0; dpr_rand = 1'b0;
      dpr_intf = N'(div); dpr_intf_valid = 1'b1; drive_inputs();
      repeat (2) tick();
      rdy_mode = 1; dpr_rand = 1'b1;
      for (int p = 0; p < N; p++) begin
        npk = $urandom_range(0, 2);
        for (int j = 0; j < npk; j++) add_pkt(p, $urandom_range(1, 4));
      end
      build_expected(div < N ? div : -1);
      drive_inputs();
      run_check("t7", 600);
      clear_obs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
